// File: rtl/perf_pkg.sv
// Shared register map, CTRL bit positions and event encoding for the
// Wishbone performance monitor.
package perf_pkg;
  localparam logic [11:0] CTRL_OFS     = 12'h000;
  localparam logic [11:0] STAT_OFS     = 12'h004;
  localparam logic [11:0] CFG_OFS      = 12'h008;
  localparam logic [11:0] CNT_BASE_OFS = 12'h100;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_SNAP   = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_IRQ_EN = 3;

  typedef enum logic [1:0] {EV_REQ, EV_ACK, EV_WAIT, EV_TXN} perf_ev_t;
endpackage

// File: rtl/perf_cnt.sv
// One live event counter plus its snapshot shadow.
// Priority: reset > clr > load > increment; snap only touches the shadow.
module perf_cnt
  import perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             snap,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic bump;
  assign bump = inc & ~clr & ~load;

  // Saturating counters flag on reaching all-ones, wrapping ones on rollover.
  if (SAT_MODE) begin : g_sat
    assign ovf = bump & (live == ONES - ONE);
  end else begin : g_wrap
    assign ovf = bump & (live == ONES);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      live   <= '0;
      shadow <= '0;
    end else if (load) begin
      live   <= load_val;
      shadow <= load_val;
    end else begin
      if (snap) shadow <= live;
      if (inc && !(SAT_MODE && live == ONES)) live <= live + ONE;
    end
  end
endmodule

// File: rtl/perf_mon.sv
// Wishbone performance monitor: four event counters per watched master,
// with snapshot, clear, sticky overflow flags and an overflow interrupt.
module perf_mon
  import perf_pkg::*;
#(
  parameter int          N_MON    = 2,
  parameter int          CNT_W    = 32,
  parameter bit          SAT_MODE = 1'b0,
  parameter logic [31:0] BASE     = 32'h9900_0000
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             wb_cyc,
  input  logic             wb_stb,
  input  logic             wb_we,
  input  logic [31:0]      wb_adr,
  input  logic [3:0]       wb_sel,
  input  logic [31:0]      wb_dat_o,
  output logic [31:0]      wb_dat_i,
  output logic             wb_ack,
  output logic             wb_rty,
  output logic             wb_err,
  input  logic [N_MON-1:0] mon_cyc,
  input  logic [N_MON-1:0] mon_stb,
  input  logic [N_MON-1:0] mon_ack,
  output logic             irq_o
);
  logic [N_MON-1:0][3:0][CNT_W-1:0] live, shadow;
  logic [N_MON-1:0][3:0]            ovf, inc, load;
  logic [4*N_MON-1:0]               ovf_flat, status;
  logic [N_MON-1:0]                 prev_cyc;
  logic                             en, irq_en;
  logic                             acc, hit, wr, ctrl_hit, stat_hit, cfg_hit, cnt_sel;
  logic                             snap_p, clr_p;
  logic [11:0]                      ofs;
  logic [2:0]                       cnt_m;
  logic [1:0]                       cnt_k;
  logic [31:0]                      rd;
  logic                             unused_ok;

  assign wb_rty    = 1'b0;
  assign wb_err    = 1'b0;
  assign unused_ok = ^{wb_sel, wb_adr[1:0], live};

  // Every strobe is acked exactly once, independent of address decode.
  assign acc      = wb_cyc & wb_stb & ~wb_ack;
  assign hit      = (wb_adr[31:12] == BASE[31:12]);
  assign ofs      = wb_adr[11:0];
  assign wr       = acc & wb_we & hit;
  assign ctrl_hit = hit && (ofs[11:2] == CTRL_OFS[11:2]);
  assign stat_hit = hit && (ofs[11:2] == STAT_OFS[11:2]);
  assign cfg_hit  = hit && (ofs[11:2] == CFG_OFS[11:2]);
  assign cnt_m    = ofs[6:4];
  assign cnt_k    = ofs[3:2];
  assign cnt_sel  = hit && (ofs[11:7] == CNT_BASE_OFS[11:7]) && (32'(cnt_m) < N_MON);
  assign snap_p   = wr & ctrl_hit & wb_dat_o[CTRL_SNAP];
  assign clr_p    = wr & ctrl_hit & wb_dat_o[CTRL_CLR];
  assign ovf_flat = ovf;

  for (genvar m = 0; m < N_MON; m++) begin : g_mon
    assign inc[m][EV_REQ]  = en & mon_cyc[m] & mon_stb[m];
    assign inc[m][EV_ACK]  = en & mon_ack[m];
    assign inc[m][EV_WAIT] = en & mon_cyc[m] & mon_stb[m] & ~mon_ack[m];
    assign inc[m][EV_TXN]  = en & mon_cyc[m] & ~prev_cyc[m];
    for (genvar k = 0; k < 4; k++) begin : g_ev
      assign load[m][k] = wr & cnt_sel & (cnt_m == 3'(m)) & (cnt_k == 2'(k));
      perf_cnt #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE)) u_cnt (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .inc      (inc[m][k]),
        .clr      (clr_p),
        .load     (load[m][k]),
        .load_val (wb_dat_o[CNT_W-1:0]),
        .snap     (snap_p),
        .live     (live[m][k]),
        .shadow   (shadow[m][k]),
        .ovf      (ovf[m][k])
      );
    end
  end

  always_comb begin
    rd = '0;
    if (ctrl_hit)      rd = 32'({irq_en, 2'b00, en});
    else if (stat_hit) rd = 32'(status);
    else if (cfg_hit)  rd = {8'd0, SAT_MODE, 7'd0, 8'(CNT_W), 8'(N_MON)};
    else if (cnt_sel) begin
      for (int m = 0; m < N_MON; m++)
        for (int k = 0; k < 4; k++)
          if (cnt_m == 3'(m) && cnt_k == 2'(k)) rd = 32'(shadow[m][k]);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack   <= 1'b0;
      wb_dat_i <= '0;
      en       <= 1'b0;
      irq_en   <= 1'b0;
      status   <= '0;
      irq_o    <= 1'b0;
      prev_cyc <= '0;
    end else begin
      wb_ack   <= acc;
      wb_dat_i <= acc ? rd : '0;
      prev_cyc <= mon_cyc;
      irq_o    <= irq_en & (|status);
      if (wr && ctrl_hit) begin
        en     <= wb_dat_o[CTRL_EN];
        irq_en <= wb_dat_o[CTRL_IRQ_EN];
      end
      // New overflows are OR'ed in after the clear so a coincident set wins.
      status <= (status & ~((wr && stat_hit) ? wb_dat_o[4*N_MON-1:0] : '0)) | ovf_flat;
    end
  end
endmodule
